// File: rtl/ws2801_receiver.sv
// ws2801_receiver: WS2801-style serial pixel receiver with idle-time frame latch.
// Define WS2801_RECEIVER_PASSTHRU_EN to forward bits after the 24th onto sdo/cko.
module ws2801_receiver #(
    parameter int FREQ     = 50_000_000,
    parameter int LATCH_US = 500
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sdi,
    input  logic        cki,
    output logic        sdo,
    output logic        cko,
    output logic [23:0] rgb,
    output logic        frame_valid,
    output logic        frame_err
);
    localparam int LATCH_CYCLES = FREQ / 1_000_000 * LATCH_US;
    localparam int CW = $clog2(LATCH_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, LOAD, FORWARD} state_t;

    state_t        state_q, state_d;
    logic          sdi_m_q, sdi_s_q, cki_m_q, cki_s_q, cki_p_q;
    logic [23:0]   shadow_q, shadow_d, rgb_q, rgb_d;
    logic [4:0]    bits_q, bits_d;
    logic [CW-1:0] idle_q, idle_d;
    logic          armed_q, armed_d, sdo_q, sdo_d, cko_q, cko_d;
    logic          fv_q, fv_d, fe_q, fe_d;
    logic          rise, fall, tc;

    assign rise = cki_s_q & ~cki_p_q;
    assign fall = ~cki_s_q & cki_p_q;
    assign tc   = idle_q == CW'(LATCH_CYCLES);

    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        bits_d   = bits_q;
        armed_d  = armed_q;
        rgb_d    = rgb_q;
        fv_d     = 1'b0;
        fe_d     = 1'b0;
        idle_d   = cki_s_q ? '0 : (tc ? idle_q : idle_q + 1'b1);
        if (tc && state_q == FORWARD) begin
            rgb_d   = shadow_q;
            fv_d    = 1'b1;
            armed_d = 1'b0;
            bits_d  = '0;
            state_d = IDLE;
        end else if (tc && state_q == LOAD) begin
            shadow_d = '0;
            bits_d   = '0;
            fe_d     = 1'b1;
            state_d  = IDLE;
        end else if (state_q == FORWARD && fall) begin
            armed_d = 1'b1;
        end
        // a rise coinciding with the latch starts the next frame
        if (rise && state_d == IDLE) begin
            shadow_d = {23'b0, sdi_s_q};
            bits_d   = 5'd1;
            state_d  = LOAD;
        end else if (rise && state_q == LOAD) begin
            shadow_d = {shadow_q[22:0], sdi_s_q};
            bits_d   = bits_q + 5'd1;
            state_d  = bits_q == 5'd23 ? FORWARD : LOAD;
        end
`ifdef WS2801_RECEIVER_PASSTHRU_EN
        sdo_d = armed_q & sdi_s_q;
        cko_d = armed_q & cki_s_q;
`else
        sdo_d = 1'b0;
        cko_d = 1'b0;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            sdi_m_q  <= 1'b0;
            sdi_s_q  <= 1'b0;
            cki_m_q  <= 1'b0;
            cki_s_q  <= 1'b0;
            cki_p_q  <= 1'b0;
            shadow_q <= '0;
            rgb_q    <= '0;
            bits_q   <= '0;
            idle_q   <= '0;
            armed_q  <= 1'b0;
            sdo_q    <= 1'b0;
            cko_q    <= 1'b0;
            fv_q     <= 1'b0;
            fe_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            sdi_m_q  <= sdi;
            sdi_s_q  <= sdi_m_q;
            cki_m_q  <= cki;
            cki_s_q  <= cki_m_q;
            cki_p_q  <= cki_s_q;
            shadow_q <= shadow_d;
            rgb_q    <= rgb_d;
            bits_q   <= bits_d;
            idle_q   <= idle_d;
            armed_q  <= armed_d;
            sdo_q    <= sdo_d;
            cko_q    <= cko_d;
            fv_q     <= fv_d;
            fe_q     <= fe_d;
        end
    end

    assign sdo         = sdo_q;
    assign cko         = cko_q;
    assign rgb         = rgb_q;
    assign frame_valid = fv_q;
    assign frame_err   = fe_q;
endmodule

// File: doc/ws2801_receiver.md
WS2801_RECEIVER -- requirements
Module: ws2801_receiver

Interface
REQ-001 SHALL have parameter FREQ, default 50_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter LATCH_US, default 500, CKI-low idle time in microseconds that latches a frame.
REQ-003 SHALL have port clk, input, 1 bit, the single system clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit, reset; asynchronous, active-high.
REQ-005 SHALL have port sdi, input, 1 bit, serial data from upstream, asynchronous to clk.
REQ-006 SHALL have port cki, input, 1 bit, serial clock from upstream, asynchronous to clk.
REQ-007 SHALL have port sdo, output, 1 bit, forwarded serial data to downstream.
REQ-008 SHALL have port cko, output, 1 bit, forwarded serial clock to downstream.
REQ-009 SHALL have port rgb, output, 24 bits, latched color; red[7] is bit 23, blue[0] is bit 0.
REQ-010 SHALL have port frame_valid, output, 1 bit, one-cycle pulse when rgb updates.
REQ-011 SHALL have port frame_err, output, 1 bit, one-cycle pulse when a partial frame (<24 bits) is discarded.

Function
REQ-012 SHALL pass sdi and cki each through a 2-flop synchronizer; the derived signals are sdi_s and cki_s.
REQ-013 SHALL detect a CKI rise as cki_s=1 with the previous cki_s=0; sdi_s SHALL be sampled in that same cycle.
REQ-014 SHALL correctly receive any cki whose high and low phases each last at least 3 clk periods; no requirement applies to faster input.
REQ-015 SHALL use states IDLE, LOAD and FORWARD; reset state is IDLE.
REQ-016 IDLE: a CKI rise SHALL shift the sampled bit into the shadow register and move to LOAD with bit count 1.
REQ-017 LOAD: each CKI rise SHALL shift the sampled bit into shadow bit 0 (left shift, MSB first); the 24th rise SHALL move to FORWARD.
REQ-018 FORWARD: shadow SHALL hold; a forward-armed flag SHALL set on the first cki_s fall after entering FORWARD.
REQ-019 While forward-armed, cko and sdo SHALL be registered copies of cki_s and sdi_s (1 clk latency past the synchronizer); otherwise both SHALL be 0.
REQ-020 An idle counter SHALL count clk cycles while cki_s=0 and SHALL clear on cki_s=1; the terminal count is LATCH_CYCLES = FREQ/1_000_000*LATCH_US.
REQ-021 At terminal count in FORWARD: rgb <= shadow, frame_valid SHALL pulse for 1 cycle in the same cycle rgb updates, forward-armed SHALL clear, and the state SHALL return to IDLE.
REQ-022 At terminal count in LOAD: shadow and bit count SHALL be discarded, rgb SHALL be unchanged, frame_err SHALL pulse for 1 cycle, and the state SHALL return to IDLE.
REQ-023 At terminal count in IDLE: no action; the counter SHALL saturate and SHALL NOT wrap.
REQ-024 A CKI rise in the same cycle as terminal count: the latch/discard SHALL take priority, and the rise SHALL be treated as the first bit of a new frame (IDLE->LOAD).
REQ-025 The bit counter SHALL be 5 bits and SHALL never exceed 24.

Reset
REQ-026 While rst=1: rgb=0, sdo=0, cko=0, frame_valid=0, frame_err=0, state=IDLE; synchronizers, shadow, counters and forward-armed SHALL be 0.
REQ-027 Reset mid-frame SHALL abandon the frame without a frame_valid or frame_err pulse; reception SHALL restart at the next CKI rise after release.

Configuration
REQ-028 Macro WS2801_RECEIVER_PASSTHRU_EN: when defined, forwarding SHALL follow REQ-018/019.
REQ-029 When the macro is undefined, sdo and cko SHALL be tied to 0 and bits after the 24th SHALL be ignored; latching SHALL be unchanged.

Verification
REQ-030 24 bits of 0x800000 at cki period 8 clk, then cki low for 500 us -> rgb=0x800000, one frame_valid pulse, sdo=cko=0 throughout.
REQ-031 48 bits {0x123456, 0xABCDEF}, then idle -> rgb=0x123456; cko shows exactly 24 rises; sdo sampled at cko rises is 0xABCDEF MSB first.
REQ-032 12 bits, then 500 us idle -> frame_err pulses once; previous rgb retained; frame_valid stays 0.
REQ-033 0xFFFFFF, latch, then 0x000001, latch -> rgb steps 0xFFFFFF then 0x000001, two frame_valid pulses.
REQ-034 rst asserted after 10 bits, released, then full 0x555555 frame -> rgb=0x555555, no frame_err.
REQ-035 Macro undefined, 48-bit frame -> sdo=cko=0 throughout, rgb=first 24 bits.
